// File: rtl/branch_history_predictor_pkg.sv
// Shared types, defaults and PC slicing helpers for the branch history predictor.
package branch_history_predictor_pkg;

    localparam int unsigned DEF_INDEX_BITS = 3;
    localparam int unsigned DEF_TAG_BITS   = 12;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    // Table index: PC[index_bits:1] (bit 0 is always zero for 2-byte instructions).
    function automatic logic [15:0] pc_index(input logic [15:0] pc, input int unsigned index_bits);
        logic [15:0] mask;
        mask = 16'((32'd1 << index_bits) - 32'd1);
        return (pc >> 1) & mask;
    endfunction

    // Tag: the tag_bits PC bits directly above the index.
    function automatic logic [15:0] pc_tag(input logic [15:0] pc, input int unsigned index_bits,
                                           input int unsigned tag_bits);
        logic [15:0] mask;
        mask = 16'((32'd1 << tag_bits) - 32'd1);
        return (pc >> (index_bits + 1)) & mask;
    endfunction

endpackage

// File: rtl/bhp_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bhp_sat_counter
    import branch_history_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    // Step toward the resolved direction, holding at either end.
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            STRONG_NT: ctr_next = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_next = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_next = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_next = taken ? STRONG_T : WEAK_T;
            default:   ctr_next = WEAK_NT;
        endcase
    end

endmodule

// File: rtl/branch_history_predictor.sv
// Fetch-stage branch direction predictor: direct-mapped table of tagged 2-bit
// counters, read combinationally with PC_curr, trained from decode.
// Optional macro BHP_BYPASS_EN: same-cycle read sees the post-update entry.
module branch_history_predictor
    import branch_history_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned TAG_BITS   = DEF_TAG_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_curr,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        enable,
    input  logic        wen,
    input  logic        actual_taken,
    output logic        predicted_taken,
    output logic        hit
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic                  valid_q [ENTRIES];
    logic                  valid_d [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d   [ENTRIES];
    ctr_t                  ctr_q   [ENTRIES];
    ctr_t                  ctr_d   [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_match;
    ctr_t                  ctr_trained;

    assign rd_idx = INDEX_BITS'(pc_index(PC_curr, INDEX_BITS));
    assign rd_tag = TAG_BITS'(pc_tag(PC_curr, INDEX_BITS, TAG_BITS));
    assign wr_idx = INDEX_BITS'(pc_index(IF_ID_PC_curr, INDEX_BITS));
    assign wr_tag = TAG_BITS'(pc_tag(IF_ID_PC_curr, INDEX_BITS, TAG_BITS));

    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    bhp_sat_counter u_sat_counter (
        .ctr      (ctr_q[wr_idx]),
        .taken    (actual_taken),
        .ctr_next (ctr_trained)
    );

    // Next table state: train on a tag hit, otherwise allocate over the occupant.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        if (enable && wen) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            if (wr_match) begin
                ctr_d[wr_idx] = ctr_trained;
            end else begin
                ctr_d[wr_idx] = actual_taken ? WEAK_T : WEAK_NT;
            end
        end
    end

    // Table storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
        end
    end

    // Zero-latency lookup; a miss always predicts not-taken.
    always_comb begin
`ifdef BHP_BYPASS_EN
        // Next-state equals stored state except at the entry being written,
        // so reading _d gives the bypass only on a same-index update.
        hit             = valid_d[rd_idx] && (tag_d[rd_idx] == rd_tag);
        predicted_taken = hit && ctr_d[rd_idx][1];
`else
        hit             = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        predicted_taken = hit && ctr_q[rd_idx][1];
`endif
    end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed self-checking bench for branch_history_predictor.
module tb_branch_history_predictor;

    logic        clk;
    logic        rst_n;
    logic [15:0] PC_curr;
    logic [15:0] IF_ID_PC_curr;
    logic        enable;
    logic        wen;
    logic        actual_taken;
    logic        predicted_taken;
    logic        hit;

    int unsigned n_checks;
    int unsigned n_fails;

    branch_history_predictor #(
        .INDEX_BITS (3),
        .TAG_BITS   (12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC_curr         (PC_curr),
        .IF_ID_PC_curr   (IF_ID_PC_curr),
        .enable          (enable),
        .wen             (wen),
        .actual_taken    (actual_taken),
        .predicted_taken (predicted_taken),
        .hit             (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    // One resolved branch, presented at a falling edge and committed at the next rising edge.
    task automatic do_update(input logic [15:0] pc, input logic taken);
        @(negedge clk);
        IF_ID_PC_curr = pc;
        enable        = 1'b1;
        wen           = 1'b1;
        actual_taken  = taken;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [15:0] pc, input logic exp_hit, input logic exp_pt);
        PC_curr = pc;
        #1;
        check_eq({tag, ".hit"}, hit, exp_hit);
        check_eq({tag, ".pt"}, predicted_taken, exp_pt);
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        PC_curr       = 16'h0002;
        IF_ID_PC_curr = 16'h0000;
        enable        = 1'b0;
        wen           = 1'b0;
        actual_taken  = 1'b0;

        // Outputs are combinational, so they are defined while reset is held.
        #2;
        probe("in_reset", 16'h0002, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            probe($sformatf("empty_idx%0d", i), 16'(i * 2), 1'b0, 1'b0);
        end

        // Allocate taken -> WEAK_T, then train down -> WEAK_NT.
        do_update(16'h0006, 1'b1);
        probe("alloc_taken", 16'h0006, 1'b1, 1'b1);
        do_update(16'h0006, 1'b0);
        probe("train_down", 16'h0006, 1'b1, 1'b0);

        // Upper saturation: alloc 10, 11, 11, 11; one not-taken -> 10.
        for (int i = 0; i < 4; i++) do_update(16'h0004, 1'b1);
        probe("sat_hi_strong", 16'h0004, 1'b1, 1'b1);
        do_update(16'h0004, 1'b0);
        probe("sat_hi_step", 16'h0004, 1'b1, 1'b1);

        // Lower saturation: 10 -> 01 -> 00 x4; one taken -> 01.
        for (int i = 0; i < 5; i++) do_update(16'h0004, 1'b0);
        probe("sat_lo_strong", 16'h0004, 1'b1, 1'b0);
        do_update(16'h0004, 1'b1);
        probe("sat_lo_step", 16'h0004, 1'b1, 1'b0);

        // Tag conflict at index 4: 0x0008 and 0x0018 differ only in tag.
        for (int i = 0; i < 3; i++) do_update(16'h0008, 1'b1);
        probe("conf_trained", 16'h0008, 1'b1, 1'b1);
        do_update(16'h0018, 1'b0);
        probe("conf_new", 16'h0018, 1'b1, 1'b0);
        probe("conf_evicted", 16'h0008, 1'b0, 1'b0);

        // Stall: wen with enable low must not write.
        @(negedge clk);
        IF_ID_PC_curr = 16'h000A;
        enable        = 1'b0;
        wen           = 1'b1;
        actual_taken  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wen    = 1'b0;
        enable = 1'b1;
        probe("stall", 16'h000A, 1'b0, 1'b0);

        // Same-cycle read and first write of index 6.
        @(negedge clk);
        PC_curr       = 16'h000C;
        IF_ID_PC_curr = 16'h000C;
        enable        = 1'b1;
        wen           = 1'b1;
        actual_taken  = 1'b1;
        #1;
`ifdef BHP_BYPASS_EN
        check_eq("same_cycle.hit", hit, 1'b1);
        check_eq("same_cycle.pt", predicted_taken, 1'b1);
`else
        check_eq("same_cycle.hit", hit, 1'b0);
        check_eq("same_cycle.pt", predicted_taken, 1'b0);
`endif
        @(posedge clk);
        #1;
        wen = 1'b0;
        probe("next_cycle", 16'h000C, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle clears the table before any edge.
        @(negedge clk);
        #1;
        probe("pre_reset", 16'h0006, 1'b1, 1'b0);
        rst_n = 1'b0;
        probe("async_rst6", 16'h0006, 1'b0, 1'b0);
        probe("async_rstC", 16'h000C, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        probe("post_reset", 16'h0004, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_history_predictor.md
Name: branch_history_predictor

Overview:
- Fetch-stage direction predictor; sits beside the branch target buffer.
- Each cycle it decides whether the PC mux takes the buffered target or PC+2.
- Holds a direct-mapped table of tagged 2-bit saturating counters, read asynchronously with the current PC.
- Trained synchronously from decode-stage branch resolution, using the pipelined IF/ID PC.

Parameters:
- INDEX_BITS, 3, table index width; the table has 2**INDEX_BITS entries; index = PC[INDEX_BITS:1].
- TAG_BITS, 12, tag width; tag = PC[INDEX_BITS+TAG_BITS:INDEX_BITS+1]; must satisfy INDEX_BITS+TAG_BITS <= 15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PC_curr  input  16  current fetch PC.
- IF_ID_PC_curr  input  16  PC of the branch being resolved in decode.
- enable  input  1  table update enable; low while stalling.
- wen  input  1  decode has resolved a branch this cycle.
- actual_taken  input  1  resolved direction of that branch.
- predicted_taken  output  1  predict taken for PC_curr.
- hit  output  1  PC_curr matches a valid entry.

Behaviour:
- Entry fields: valid (1), tag (TAG_BITS), ctr (2).
- Counter encoding: 2'b00 STRONG_NT, 2'b01 WEAK_NT, 2'b10 WEAK_T, 2'b11 STRONG_T.
- Reset (asynchronous, rst_n low): every valid=0, tag=0, ctr=WEAK_NT. Outputs are combinational, so during reset hit=0 and predicted_taken=0.
- Read path (zero latency, combinational):
  - hit = valid[idx] && tag[idx]==tag(PC_curr).
  - predicted_taken = hit && ctr[idx][1].
  - A miss always predicts not-taken.
- Update happens at the rising edge when enable && wen. The entry is selected by the index of IF_ID_PC_curr.
  - Tag match and valid (train):
    - actual_taken=1: ctr = ctr+1, saturating at 2'b11.
    - actual_taken=0: ctr = ctr-1, saturating at 2'b00.
  - Invalid entry or tag mismatch (allocate): valid=1, tag=tag(IF_ID_PC_curr), ctr = actual_taken ? WEAK_T : WEAK_NT. An allocation overwrites any previous occupant.
- enable low: no state change, regardless of wen.
- Same-index read and write in one cycle: the read returns the pre-update entry (no bypass), unless the optional feature below is compiled in.
- rst_n asserted mid-update: reset wins and the table is cleared immediately.
- Stall cycles: PC_curr is held by the fetch stage, so the outputs stay stable.

Optional Feature:
- Macro: BHP_BYPASS_EN.
- Defined: when enable && wen and IF_ID_PC_curr indexes the same entry as PC_curr, hit and predicted_taken are computed from the post-update (next-state) entry in the same cycle.
- Undefined: the read reflects stored state only, so the update is visible from the next cycle.

Decomposition:
- Shared package holds:
  - counter typedef and the four state constants;
  - default INDEX_BITS/TAG_BITS;
  - index/tag slice helper functions.
- One sub-module, bhp_sat_counter: a combinational 2-bit saturating next-state function (inputs ctr and taken, output next ctr), used by the update path and the bypass path.

Test Plan:
- Reset, then PC_curr=16'h0002 -> hit=0, predicted_taken=0; every index misses.
- One taken update at IF_ID_PC_curr=16'h0006 (enable=1, wen=1, actual_taken=1), then PC_curr=16'h0006 -> hit=1, predicted_taken=1 (WEAK_T). Then one not-taken update -> predicted_taken=0 (WEAK_NT).
- Saturation at PC 16'h0004:
  - four taken updates, then one not-taken -> predicted_taken stays 1 (11 to 10);
  - then five not-taken, then one taken -> predicted_taken=0 (00 to 01).
- Tag conflict:
  - train 16'h0008 to STRONG_T;
  - not-taken update at 16'h0018 (same index, new tag) -> PC_curr=16'h0018 gives hit=1, predicted_taken=0, and PC_curr=16'h0008 gives hit=0.
- Stall: enable=0, wen=1, actual_taken=1 at 16'h000A for 3 cycles -> PC_curr=16'h000A still hit=0.
- Same-cycle access: PC_curr=IF_ID_PC_curr=16'h000C, first taken update
  - without BHP_BYPASS_EN: hit=0 in that cycle, hit=1 the next;
  - with BHP_BYPASS_EN: hit=1, predicted_taken=1 in the same cycle.
- Pulse rst_n low asynchronously mid-cycle after training -> hit=0 immediately, before the next edge.
